// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, state codes and helpers for the divider
package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Two's-complement negate, kept at 32 bits.
  function automatic logic [RegBus-1:0] neg32(input logic [RegBus-1:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of an operand: only negative values of a signed divide are flipped.
  function automatic logic [RegBus-1:0] mag32(input logic is_signed, input logic [RegBus-1:0] v);
    return (is_signed && v[RegBus-1]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/div_if.sv
// rtl/div_if.sv - execute-stage request/result bundle for the divider
interface div_if;
  import div_pkg::*;

  logic                    signed_div_i;
  logic [RegBus-1:0]       opdata1_i;
  logic [RegBus-1:0]       opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [DoubleRegBus-1:0] result_o;
  logic                    ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div.sv
// rtl/div.sv - restoring shift-subtract 32-bit divider; DIV_EARLY_TERM_EN enables the small-dividend early-out
module div
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  div_state_e              r_state;
  logic [5:0]              r_cnt;
  // Low 64 bits of the 65-bit working register. Bit 64 is always zero
  // while iterating (the partial remainder stays below 2^31 until the last
  // step), so it only exists in the next-value wire used for the final result.
  logic [63:0]             r_work;
  logic [RegBus-1:0]       r_divisor;
  logic                    r_neg_quot;
  logic                    r_neg_rem;
  logic                    r_ready;
  logic [DoubleRegBus-1:0] r_result;

  logic [RegBus-1:0]       w_dividend_mag;
  logic [RegBus-1:0]       w_divisor_mag;
  logic [RegBus:0]         w_diff;
  logic [64:0]             w_work_nxt;
  logic [5:0]              w_cnt_nxt;
  logic [RegBus-1:0]       w_quot_fix;
  logic [RegBus-1:0]       w_rem_fix;

  // Operand magnitudes, one restoring step, and sign fixup of the step's output.
  always_comb begin
    w_dividend_mag = mag32(bus.signed_div_i, bus.opdata1_i);
    w_divisor_mag  = mag32(bus.signed_div_i, bus.opdata2_i);
    w_diff         = {1'b0, r_work[63:32]} - {1'b0, r_divisor};
    if (w_diff[RegBus]) begin
      w_work_nxt = {r_work, 1'b0};
    end else begin
      w_work_nxt = {w_diff[RegBus-1:0], r_work[31:0], 1'b1};
    end
    w_cnt_nxt  = r_cnt + 6'd1;
    w_quot_fix = r_neg_quot ? neg32(w_work_nxt[31:0])  : w_work_nxt[31:0];
    w_rem_fix  = r_neg_rem  ? neg32(w_work_nxt[64:33]) : w_work_nxt[64:33];
  end

  // Divider FSM: accept, iterate 32 times, present result until start drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= DivFree;
      r_cnt      <= 6'd0;
      r_work     <= '0;
      r_divisor  <= '0;
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_ready    <= DivResultNotReady;
      r_result   <= '0;
    end else begin
      case (r_state)
        DivFree: begin
          r_ready  <= DivResultNotReady;
          r_result <= '0;
          r_cnt    <= 6'd0;
          // annul wins over a simultaneous start
          if (bus.start_i == DivStart && !bus.annul_i) begin
            r_divisor  <= w_divisor_mag;
            r_neg_quot <= bus.signed_div_i & (bus.opdata1_i[RegBus-1] ^ bus.opdata2_i[RegBus-1]);
            r_neg_rem  <= bus.signed_div_i & bus.opdata1_i[RegBus-1];
            r_work     <= {31'b0, w_dividend_mag, 1'b0};
            if (w_divisor_mag == '0) begin
              r_state <= DivByZero;
`ifdef DIV_EARLY_TERM_EN
            end else if (w_dividend_mag < w_divisor_mag) begin
              // quotient is zero and the remainder is the dividend itself
              r_state  <= DivEnd;
              r_ready  <= DivResultReady;
              r_result <= {bus.opdata1_i, 32'h0};
`endif
            end else begin
              r_state <= DivOn;
            end
          end
        end

        DivByZero: begin
          if (bus.annul_i) begin
            r_state  <= DivFree;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end else begin
            r_state  <= DivEnd;
            r_ready  <= DivResultReady;
            r_result <= '0;
          end
        end

        DivOn: begin
          if (bus.annul_i) begin
            r_state  <= DivFree;
            r_cnt    <= 6'd0;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end else begin
            r_work <= w_work_nxt[63:0];
            // the step that brings cnt to 32 also publishes the result
            if (w_cnt_nxt == 6'd32) begin
              r_state  <= DivEnd;
              r_cnt    <= 6'd0;
              r_ready  <= DivResultReady;
              r_result <= {w_rem_fix, w_quot_fix};
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end

        DivEnd: begin
          if (bus.annul_i || bus.start_i == DivStop) begin
            r_state  <= DivFree;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end else begin
            r_ready <= DivResultReady;
          end
        end

        default: begin
          r_state  <= DivFree;
          r_ready  <= DivResultNotReady;
          r_result <= '0;
        end
      endcase
    end
  end

  assign bus.ready_o  = r_ready;
  assign bus.result_o = r_result;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for the divider
module tb_div;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  div_if bus();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present an operation on the next falling edge; the following rising edge accepts it.
  task automatic drive_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
  endtask

  // Count rising edges (accepting edge included) until ready is seen, bounded.
  task automatic wait_ready(input int already, output int lat);
    lat = already;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (bus.ready_o !== 1'b1 && lat < 40);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.ready_o); end
    n_cmp++;
    if (bus.result_o !== 64'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
    rst = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat;
    drive_op(1'b0, 32'd100, 32'd7);
    @(posedge clk);
    @(negedge clk);
    bus.opdata1_i = 32'hDEAD_BEEF;
    bus.opdata2_i = 32'd1;
    wait_ready(1, lat);
    n_cmp++;
    if (lat !== 33) begin n_err++; $display("FAIL u100_7_latency: got %0d want 33", lat); end
    n_cmp++;
    if (bus.result_o !== {32'd2, 32'd14}) begin n_err++; $display("FAIL u100_7_result: got %h want %h", bus.result_o, {32'd2, 32'd14}); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== {32'd2, 32'd14}) begin
        n_err++;
        $display("FAIL u100_7_hold%0d: got ready=%b result=%h want ready=1 result=%h", i, bus.ready_o, bus.result_o, {32'd2, 32'd14});
      end
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      n_err++;
      $display("FAIL u100_7_release: got ready=%b result=%h want ready=0 result=0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_sign_table();
    logic        v_s   [6];
    logic [31:0] v_a   [6];
    logic [31:0] v_b   [6];
    logic [63:0] v_exp [6];
    int lat;
    v_s[0] = 1'b1; v_a[0] = 32'hFFFF_FFF9; v_b[0] = 32'd2;          v_exp[0] = 64'hFFFF_FFFF_FFFF_FFFD;
    v_s[1] = 1'b1; v_a[1] = 32'h8000_0000; v_b[1] = 32'hFFFF_FFFF; v_exp[1] = 64'h0000_0000_8000_0000;
    v_s[2] = 1'b0; v_a[2] = 32'hFFFF_FFF9; v_b[2] = 32'd2;          v_exp[2] = 64'h0000_0001_7FFF_FFFC;
    v_s[3] = 1'b1; v_a[3] = 32'd7;         v_b[3] = 32'hFFFF_FFFE; v_exp[3] = 64'h0000_0001_FFFF_FFFD;
    v_s[4] = 1'b1; v_a[4] = 32'hFFFF_FFF9; v_b[4] = 32'hFFFF_FFFE; v_exp[4] = 64'hFFFF_FFFF_0000_0003;
    v_s[5] = 1'b0; v_a[5] = 32'hFFFF_FFFF; v_b[5] = 32'hFFFF_FFFE; v_exp[5] = 64'h0000_0001_0000_0001;
    for (int i = 0; i < 6; i++) begin
      drive_op(v_s[i], v_a[i], v_b[i]);
      wait_ready(0, lat);
      n_cmp++;
      if (lat !== 33 || bus.result_o !== v_exp[i]) begin
        n_err++;
        $display("FAIL sign_vec%0d: got lat=%0d result=%h want lat=33 result=%h", i, lat, bus.result_o, v_exp[i]);
      end
      bus.start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    drive_op(1'b0, 32'd5, 32'd0);
    wait_ready(0, lat);
    n_cmp++;
    if (lat !== 2) begin n_err++; $display("FAIL div0_latency: got %0d want 2", lat); end
    n_cmp++;
    if (bus.result_o !== 64'h0) begin n_err++; $display("FAIL div0_result: got %h want 0", bus.result_o); end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL div0_release: got ready=%b want 0", bus.ready_o); end
  endtask

  task automatic test_annul();
    int lat;
    drive_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL annul_ready: got %b want 0", bus.ready_o); end
    bus.annul_i   = 1'b0;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    wait_ready(0, lat);
    n_cmp++;
    if (lat !== 33 || bus.result_o !== {32'd0, 32'd3}) begin
      n_err++;
      $display("FAIL annul_restart: got lat=%0d result=%h want lat=33 result=%h", lat, bus.result_o, {32'd0, 32'd3});
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat;
    drive_op(1'b0, 32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      n_err++;
      $display("FAIL rst_abort: got ready=%b result=%h want ready=0 result=0", bus.ready_o, bus.result_o);
    end
    rst = 1'b1;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    wait_ready(0, lat);
    n_cmp++;
    if (lat !== 33 || bus.result_o !== {32'd0, 32'd3}) begin
      n_err++;
      $display("FAIL rst_restart: got lat=%0d result=%h want lat=33 result=%h", lat, bus.result_o, {32'd0, 32'd3});
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_annul_priority();
    int lat;
    drive_op(1'b0, 32'd100, 32'd7);
    bus.annul_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL annul_prio%0d: got ready=%b want 0", i, bus.ready_o); end
    end
    bus.annul_i = 1'b0;
    wait_ready(0, lat);
    n_cmp++;
    if (lat !== 33 || bus.result_o !== {32'd2, 32'd14}) begin
      n_err++;
      $display("FAIL annul_prio_start: got lat=%0d result=%h want lat=33 result=%h", lat, bus.result_o, {32'd2, 32'd14});
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_small_dividend();
    int exp_lat;
    int lat;
`ifdef DIV_EARLY_TERM_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    drive_op(1'b0, 32'd3, 32'd10);
    wait_ready(0, lat);
    n_cmp++;
    if (lat !== exp_lat || bus.result_o !== {32'd3, 32'd0}) begin
      n_err++;
      $display("FAIL small_u3_10: got lat=%0d result=%h want lat=%0d result=%h", lat, bus.result_o, exp_lat, {32'd3, 32'd0});
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_op(1'b1, 32'hFFFF_FFFD, 32'd10);
    wait_ready(0, lat);
    n_cmp++;
    if (lat !== exp_lat || bus.result_o !== 64'hFFFF_FFFD_0000_0000) begin
      n_err++;
      $display("FAIL small_sm3_10: got lat=%0d result=%h want lat=%0d result=%h", lat, bus.result_o, exp_lat, 64'hFFFF_FFFD_0000_0000);
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_op(1'b0, 32'd50, 32'd5);
    wait_ready(0, lat);
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.opdata1_i = 32'd51;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    wait_ready(0, lat);
    n_cmp++;
    if (lat !== 33 || bus.result_o !== {32'd1, 32'd10}) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d result=%h want lat=33 result=%h", lat, bus.result_o, {32'd1, 32'd10});
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_sign_table();
    test_div_by_zero();
    test_annul();
    test_reset_abort();
    test_annul_priority();
    test_small_dividend();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
